// File: rtl/tx_bank_sched.sv
// rtl/tx_bank_sched.sv - ping-pong bank scheduler for the double-buffered TX RAM
//
// Purpose: hands a free bank to the packet decoder, generates RAM write
// addresses, queues completed banks and passes them in fill order to the USB
// slave FIFO, recovering a bank if the FIFO never reports completion.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_sop/wr_vd/wr_eop decoder packet start, data word, packet end
//   wr_ready            a bank is available for wr_sop (registered)
//   wr_en/wr_addr       RAM write strobe and {bank, offset} address
//   wr_ovf              sticky: a word was dropped on a full bank
//   ep_full             EP6 full flag
//   tx_start/tx_bank/tx_len  handover pulse, bank index, word count
//   tx_done             slave FIFO finished the bank
//   tx_abort/err_to     timeout pulse and sticky timeout flag
//   pend_cnt            banks in READY or SENDING
module tx_bank_sched #(
  parameter int ADDR_NBIT = 8,
  parameter int TO_NBIT   = 16,
  parameter int TIMEOUT   = 48000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_sop,
  input  logic                 wr_vd,
  input  logic                 wr_eop,
  output logic                 wr_ready,
  output logic                 wr_en,
  output logic [ADDR_NBIT:0]   wr_addr,
  output logic                 wr_ovf,
  input  logic                 ep_full,
  output logic                 tx_start,
  output logic                 tx_bank,
  output logic [ADDR_NBIT:0]   tx_len,
  input  logic                 tx_done,
  output logic                 tx_abort,
  output logic                 err_to,
  output logic [1:0]           pend_cnt
);

  typedef enum logic [1:0] {B_FREE, B_FILLING, B_READY, B_SENDING} bank_t;
  typedef enum logic {W_IDLE, W_FILL} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_WAIT} rstate_t;

  localparam logic [TO_NBIT-1:0] TO_LAST = TO_NBIT'(TIMEOUT - 1);

  bank_t              bank_q [2];
  bank_t              bank_d [2];
  logic [ADDR_NBIT:0] len_q  [2];
  logic [ADDR_NBIT:0] len_d  [2];
  wstate_t            ws_q, ws_d;
  rstate_t            rs_q, rs_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [ADDR_NBIT:0] offset_q, offset_d;
  logic [TO_NBIT-1:0] to_q, to_d;
  logic               wr_ovf_d, err_to_d, tx_bank_d, wr_ready_d;
  logic [ADDR_NBIT:0] tx_len_d, pkt_len;
  logic [1:0]         pend_d;
  logic               accept, timeout_hit;

  always_comb begin
    bank_d[0]  = bank_q[0];
    bank_d[1]  = bank_q[1];
    len_d[0]   = len_q[0];
    len_d[1]   = len_q[1];
    ws_d       = ws_q;
    rs_d       = rs_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    offset_d   = offset_q;
    to_d       = to_q;
    wr_ovf_d   = wr_ovf;
    err_to_d   = err_to;
    tx_bank_d  = tx_bank;
    tx_len_d   = tx_len;
    tx_abort   = 1'b0;

    // offset never exceeds DEPTH, so its MSB alone means "bank full"
    accept      = (ws_q == W_FILL) && wr_vd && !offset_q[ADDR_NBIT];
    pkt_len     = offset_q + {{ADDR_NBIT{1'b0}}, accept};
    timeout_hit = (rs_q == R_WAIT) && !tx_done && (to_q == TO_LAST);

    case (ws_q)
      W_IDLE: begin
        if (wr_sop && wr_ready) begin
          ws_d             = W_FILL;
          bank_d[wr_ptr_q] = B_FILLING;
          offset_d         = '0;
        end
      end
      default: begin
        if (accept) offset_d = offset_q + (ADDR_NBIT+1)'(1);
        if (wr_vd && offset_q[ADDR_NBIT]) wr_ovf_d = 1'b1;
        if (wr_eop) begin
          ws_d = W_IDLE;
          if (pkt_len == '0) begin
            bank_d[wr_ptr_q] = B_FREE;
          end else begin
            bank_d[wr_ptr_q] = B_READY;
            len_d[wr_ptr_q]  = pkt_len;
            wr_ptr_d         = ~wr_ptr_q;
          end
        end
      end
    endcase

    // The reader only ever touches READY/SENDING banks and the writer only
    // FREE/FILLING ones, so both updates can apply in the same cycle.
    case (rs_q)
      R_IDLE: begin
        if ((bank_q[rd_ptr_q] == B_READY) && !ep_full) begin
          rs_d      = R_START;
          tx_bank_d = rd_ptr_q;
          tx_len_d  = len_q[rd_ptr_q];
        end
      end
      R_START: begin
        bank_d[rd_ptr_q] = B_SENDING;
        to_d             = '0;
        rs_d             = R_WAIT;
      end
      R_WAIT: begin
        if (tx_done || timeout_hit) begin
          bank_d[rd_ptr_q] = B_FREE;
          rd_ptr_d         = ~rd_ptr_q;
          rs_d             = R_IDLE;
        end else begin
          to_d = to_q + TO_NBIT'(1);
        end
        if (timeout_hit) begin
          tx_abort = 1'b1;
          err_to_d = 1'b1;
        end
      end
      default: rs_d = R_IDLE;
    endcase

    // Registered from next state so they match the bank states exactly
    wr_ready_d = (ws_d == W_IDLE) && (bank_d[wr_ptr_d] == B_FREE);
    pend_d     = {1'b0, (bank_d[0] == B_READY) || (bank_d[0] == B_SENDING)}
               + {1'b0, (bank_d[1] == B_READY) || (bank_d[1] == B_SENDING)};
  end

  assign wr_en    = accept;
  assign wr_addr  = (ws_q == W_FILL) ? {wr_ptr_q, offset_q[ADDR_NBIT-1:0]} : '0;
  assign tx_start = (rs_q == R_START);

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q[0] <= B_FREE;
      bank_q[1] <= B_FREE;
      len_q[0]  <= '0;
      len_q[1]  <= '0;
      ws_q      <= W_IDLE;
      rs_q      <= R_IDLE;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      offset_q  <= '0;
      to_q      <= '0;
      wr_ovf    <= 1'b0;
      err_to    <= 1'b0;
      tx_bank   <= 1'b0;
      tx_len    <= '0;
      wr_ready  <= 1'b0;
      pend_cnt  <= 2'd0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      len_q[0]  <= len_d[0];
      len_q[1]  <= len_d[1];
      ws_q      <= ws_d;
      rs_q      <= rs_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      offset_q  <= offset_d;
      to_q      <= to_d;
      wr_ovf    <= wr_ovf_d;
      err_to    <= err_to_d;
      tx_bank   <= tx_bank_d;
      tx_len    <= tx_len_d;
      wr_ready  <= wr_ready_d;
      pend_cnt  <= pend_d;
    end
  end

endmodule

// File: tb/tb_tx_bank_sched.sv
// tb/tb_tx_bank_sched.sv - directed self-checking bench for tx_bank_sched
module tb_tx_bank_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_sop = 1'b0, wr_vd = 1'b0, wr_eop = 1'b0;
  logic       wr_ready, wr_en, wr_ovf;
  logic [8:0] wr_addr;
  logic       ep_full = 1'b0;
  logic       tx_start, tx_bank, tx_abort, err_to;
  logic [8:0] tx_len;
  logic       tx_done = 1'b0;
  logic [1:0] pend_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int n_start = 0, n_abort = 0, n_wr = 0;
  int last_start_cyc = 0, last_abort_cyc = 0;

  tx_bank_sched #(.ADDR_NBIT(8), .TO_NBIT(16), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .wr_sop(wr_sop), .wr_vd(wr_vd), .wr_eop(wr_eop),
    .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_ovf(wr_ovf),
    .ep_full(ep_full),
    .tx_start(tx_start), .tx_bank(tx_bank), .tx_len(tx_len),
    .tx_done(tx_done), .tx_abort(tx_abort), .err_to(err_to),
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_start) begin
      n_start <= n_start + 1;
      last_start_cyc <= cyc;
    end
    if (tx_abort) begin
      n_abort <= n_abort + 1;
      last_abort_cyc <= cyc;
    end
    if (wr_en) n_wr <= n_wr + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk1();
    clk1();
    rst = 1'b0;
    clk1();
  endtask

  // Starts at a cycle with wr_ready expected high; eop rides on the last word.
  task automatic send_pkt(input int n, input int bank);
    wr_sop = 1'b1;
    #2;
    check("sop_ready", wr_ready, 1);
    clk1();
    wr_sop = 1'b0;
    if (n == 0) begin
      wr_eop = 1'b1;
      clk1();
    end
    for (int i = 0; i < n; i++) begin
      wr_vd  = 1'b1;
      wr_eop = (i == n - 1);
      #2;
      if (i < 256) begin
        check("wr_en", wr_en, 1);
        check("wr_addr", wr_addr, bank * 256 + i);
      end else begin
        check("wr_en_drop", wr_en, 0);
      end
      clk1();
    end
    wr_vd  = 1'b0;
    wr_eop = 1'b0;
  endtask

  task automatic wait_start(input int limit);
    int s;
    s = n_start;
    for (int k = 0; k < limit && n_start == s; k++) clk1();
    check("start_seen", n_start != s, 1);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    clk1();
    tx_done = 1'b0;
  endtask

  int e, t, s0, a0, w0;

  initial begin
    clk1();
    clk1();
    #2;
    check("rst_wr_ready", wr_ready, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_tx_len", tx_len, 0);
    check("rst_pend", pend_cnt, 0);
    check("rst_flags", {wr_en, wr_ovf, tx_start, tx_bank, tx_abort, err_to}, 0);
    rst = 1'b0;
    #1;
    check("ready_still_low", wr_ready, 0);
    clk1();
    check("ready_after_rst", wr_ready, 1);

    // single 4-word packet
    e = cyc + 4;
    send_pkt(4, 0);
    #2;
    check("p1_pend", pend_cnt, 1);
    wait_start(20);
    check("p1_latency", last_start_cyc - e, 2);
    check("p1_bank", tx_bank, 0);
    check("p1_len", tx_len, 4);
    pulse_done();
    #2;
    check("p1_pend_done", pend_cnt, 0);

    // ping-pong with tx_done withheld
    do_reset();
    s0 = n_start;
    send_pkt(10, 0);
    send_pkt(10, 1);
    #2;
    check("pp_ready_low", wr_ready, 0);
    check("pp_pend2", pend_cnt, 2);
    check("pp_one_start", n_start - s0, 1);
    check("pp_bank0", tx_bank, 0);
    check("pp_len0", tx_len, 10);
    clk1(); clk1(); clk1();
    check("pp_no_2nd", n_start - s0, 1);
    tx_done = 1'b1;
    t = cyc;
    #1;
    check("pp_ready_same", wr_ready, 0);
    clk1();
    tx_done = 1'b0;
    #2;
    check("pp_ready_next", wr_ready, 1);
    check("pp_pend1", pend_cnt, 1);
    wait_start(10);
    check("pp_latency", last_start_cyc - t, 2);
    check("pp_bank1", tx_bank, 1);
    check("pp_len1", tx_len, 10);
    pulse_done();
    #2;
    check("pp_pend0", pend_cnt, 0);

    // overflow: 258 words into bank 0
    check("ovf_clear", wr_ovf, 0);
    w0 = n_wr;
    send_pkt(258, 0);
    #2;
    check("ovf_set", wr_ovf, 1);
    check("ovf_writes", n_wr - w0, 256);
    wait_start(10);
    check("ovf_len", tx_len, 256);
    check("ovf_bank", tx_bank, 0);
    pulse_done();

    // backpressure on bank 1
    ep_full = 1'b1;
    s0 = n_start;
    send_pkt(3, 1);
    repeat (5) clk1();
    check("bp_no_start", n_start - s0, 0);
    check("bp_pend", pend_cnt, 1);
    ep_full = 1'b0;
    t = cyc;
    wait_start(10);
    check("bp_latency", last_start_cyc - t, 1);
    check("bp_len", tx_len, 3);
    pulse_done();

    // timeout on bank 0
    a0 = n_abort;
    send_pkt(2, 0);
    wait_start(10);
    t = last_start_cyc;
    for (int k = 0; k < 40 && n_abort == a0; k++) clk1();
    check("to_abort_seen", n_abort - a0, 1);
    check("to_abort_cyc", last_abort_cyc - t, 16);
    #2;
    check("to_err", err_to, 1);
    check("to_pend", pend_cnt, 0);
    send_pkt(1, 1);
    wait_start(10);
    check("to_reuse_bank", tx_bank, 1);
    check("to_reuse_len", tx_len, 1);
    pulse_done();

    // tx_done on the timeout cycle wins
    a0 = n_abort;
    send_pkt(2, 0);
    wait_start(10);
    repeat (15) clk1();
    pulse_done();
    repeat (3) clk1();
    check("done_wins_abort", n_abort - a0, 0);
    check("done_wins_pend", pend_cnt, 0);

    // empty packet, then reset while waiting
    do_reset();
    check("rst2_err", err_to, 0);
    check("rst2_ovf", wr_ovf, 0);
    s0 = n_start;
    send_pkt(0, 0);
    repeat (6) clk1();
    check("empty_no_start", n_start - s0, 0);
    check("empty_pend", pend_cnt, 0);
    check("empty_ready", wr_ready, 1);
    send_pkt(1, 0);
    wait_start(10);
    clk1(); clk1(); clk1();
    rst = 1'b1;
    clk1();
    rst = 1'b0;
    #2;
    check("midrst_pend", pend_cnt, 0);
    check("midrst_len", tx_len, 0);
    clk1();
    check("midrst_ready", wr_ready, 1);
    a0 = n_abort;
    s0 = n_start;
    repeat (25) clk1();
    check("midrst_no_abort", n_abort - a0, 0);
    check("midrst_no_start", n_start - s0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
